// File: rtl/score_display_ctrl.sv
// Pong scoreboard: two 2-digit BCD scores, PLAY/GAME_OVER match FSM, four HEX digits.
// Latency: a point/new_game pulse at edge N shows on scores and HEX at edge N+1.
// No backpressure: every cycle a point input is high counts as one point.

// BCD digit to active-low seven-segment pattern (segment order g..a).
module seven_seg (
  input  logic [3:0] digit_dat,
  output logic [6:0] seg_n
);

  // Pure decode; codes above 9 never occur on a BCD score and show blank.
  always_comb begin
    seg_n = 7'b1111111;
    case (digit_dat)
      4'd0:    seg_n = 7'b1000000;
      4'd1:    seg_n = 7'b1111001;
      4'd2:    seg_n = 7'b0100100;
      4'd3:    seg_n = 7'b0110000;
      4'd4:    seg_n = 7'b0011001;
      4'd5:    seg_n = 7'b0010010;
      4'd6:    seg_n = 7'b0000010;
      4'd7:    seg_n = 7'b1111000;
      4'd8:    seg_n = 7'b0000000;
      4'd9:    seg_n = 7'b0010000;
      default: seg_n = 7'b1111111;
    endcase
  end

endmodule

module score_display_ctrl #(
  parameter int WIN_SCORE  = 11,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       new_game,
  output logic [7:0] score_p1,
  output logic [7:0] score_p2,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  // Winning score expressed in BCD so it can be compared directly to the score registers.
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

  // Blink counter only needs to reach BLINK_HALF-1; keep at least one bit.
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } state_t;

  state_t          state_q,     state_d;
  logic [7:0]      score_p1_q,  score_p1_d;
  logic [7:0]      score_p2_q,  score_p2_d;
  logic            game_over_q, game_over_d;
  logic [1:0]      winner_q,    winner_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_hide_q, blink_hide_d;

  logic            reach_p1;
  logic            reach_p2;

  // Saturating BCD increment: 09 -> 10, 99 stays 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
        r[3:0] = 4'd0;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Next-state for scores, match FSM and blink timer; new_game overrides everything.
  always_comb begin
    state_d      = state_q;
    score_p1_d   = score_p1_q;
    score_p2_d   = score_p2_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    blink_cnt_d  = blink_cnt_q;
    blink_hide_d = blink_hide_q;
    reach_p1     = 1'b0;
    reach_p2     = 1'b0;

    if (new_game) begin
      state_d      = ST_PLAY;
      score_p1_d   = 8'h00;
      score_p2_d   = 8'h00;
      game_over_d  = 1'b0;
      winner_d     = 2'b00;
      blink_cnt_d  = '0;
      blink_hide_d = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (point_p1) begin
            score_p1_d = bcd_inc(score_p1_q);
          end
          if (point_p2) begin
            score_p2_d = bcd_inc(score_p2_q);
          end
          // A player can only sit below the target while in PLAY, so hitting
          // it on this edge means they scored the deciding point just now.
          reach_p1 = point_p1 && (score_p1_d == WIN_BCD);
          reach_p2 = point_p2 && (score_p2_d == WIN_BCD);
          if (reach_p1 || reach_p2) begin
            state_d      = ST_OVER;
            game_over_d  = 1'b1;
            winner_d     = {reach_p2, reach_p1};
            blink_cnt_d  = '0;
            blink_hide_d = 1'b0;
          end
        end
        ST_OVER: begin
          // Scores frozen; only the blink timer advances.
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d  = '0;
            blink_hide_d = ~blink_hide_q;
          end else begin
            blink_cnt_d  = blink_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_PLAY;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset; reset beats any pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_PLAY;
      score_p1_q   <= 8'h00;
      score_p2_q   <= 8'h00;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      blink_cnt_q  <= '0;
      blink_hide_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_hide_q <= blink_hide_d;
    end
  end

  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

  logic [6:0] seg_p1_tens;
  logic [6:0] seg_p1_ones;
  logic [6:0] seg_p2_tens;
  logic [6:0] seg_p2_ones;

  seven_seg u_seg_p1_tens (.digit_dat(score_p1_q[7:4]), .seg_n(seg_p1_tens));
  seven_seg u_seg_p1_ones (.digit_dat(score_p1_q[3:0]), .seg_n(seg_p1_ones));
  seven_seg u_seg_p2_tens (.digit_dat(score_p2_q[7:4]), .seg_n(seg_p2_tens));
  seven_seg u_seg_p2_ones (.digit_dat(score_p2_q[3:0]), .seg_n(seg_p2_ones));

  logic hide_p1;
  logic hide_p2;

  // Display muxing: blank leading-zero tens, then blank the winner's digits in the hidden phase.
  always_comb begin
    hide_p1 = game_over_q && blink_hide_q && winner_q[0];
    hide_p2 = game_over_q && blink_hide_q && winner_q[1];

    HEX3 = (score_p1_q[7:4] == 4'd0) ? SEG_BLANK : seg_p1_tens;
    HEX2 = seg_p1_ones;
    HEX1 = (score_p2_q[7:4] == 4'd0) ? SEG_BLANK : seg_p2_tens;
    HEX0 = seg_p2_ones;

    if (hide_p1) begin
      HEX3 = SEG_BLANK;
      HEX2 = SEG_BLANK;
    end
    if (hide_p2) begin
      HEX1 = SEG_BLANK;
      HEX0 = SEG_BLANK;
    end
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
Score-keeping and display controller for the Pong scoreboard on the DE1-SoC HEX displays. Takes single-cycle point pulses from the ball/collision logic and holds both players' scores as 2-digit BCD. Runs the PLAY/GAME_OVER match state and drives four HEX digits through internal seven_seg decoder instances. Adds leading-zero blanking and blinks the winner's digits at match end.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..99.
BLINK_HALF, 25_000_000, cycles per blink half-period (0.5 s at 50 MHz); minimum 1.

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  synchronous reset, active low
point_p1  in  1  1-cycle pulse: player 1 scored
point_p2  in  1  1-cycle pulse: player 2 scored
new_game  in  1  1-cycle pulse: clear scores and restart the match
score_p1  out  8  player 1 score, BCD {tens,ones}
score_p2  out  8  player 2 score, BCD {tens,ones}
game_over  out  1  high while in GAME_OVER
winner  out  2  00 none, 01 P1, 10 P2, 11 draw
HEX0  out  7  P2 ones digit, active-low segments
HEX1  out  7  P2 tens digit, active-low segments
HEX2  out  7  P1 ones digit, active-low segments
HEX3  out  7  P1 tens digit, active-low segments

Behaviour:
- Clock and reset: single clock domain. All state updates on the rising edge of clk. rst_n is sampled only at the edge (synchronous, active low).
- Reset values: state=PLAY, score_p1=score_p2=8'h00, game_over=0, winner=00, blink counter=0, blink phase=visible. HEX0=HEX2=7'b1000000 ("0"). HEX1=HEX3=7'b1111111 (tens blanked).
- Reset mid-match or mid-blink: all state returns to the reset values at the next edge. Point or new_game pulses in that same cycle are ignored.
- FSM, state PLAY:
  - point_pX increments that player's BCD score at the next edge.
  - Ones digit 9 -> 0 with carry into tens.
  - Score saturates at 99; no wrap.
- Simultaneous point_p1 and point_p2: both scores increment in the same cycle.
- PLAY -> GAME_OVER: taken on the same edge that any score becomes equal to WIN_SCORE.
  - winner = 01 if only P1 reached WIN_SCORE, 10 if only P2, 11 if both reached it on that edge.
  - game_over and winner are valid in the same cycle as the final score.
- FSM, state GAME_OVER:
  - point pulses are ignored; scores are frozen.
  - Blink counter counts 0..BLINK_HALF-1, then wraps and toggles the blink phase.
  - On entry: counter=0 and phase=visible.
- new_game:
  - From either state, at the next edge: scores=00, winner=00, game_over=0, state=PLAY, counter and phase reset.
  - new_game has priority over point pulses in the same cycle; those points are dropped.
- Latency: an input pulse at edge N is reflected on scores and HEX at edge N+1. HEX outputs are combinational from registered state; no extra pipeline stage.
- Display:
  - Each BCD digit goes through its own seven_seg instance.
  - A tens digit of 0 is blanked (7'b1111111).
  - In GAME_OVER with blink phase hidden, all digits of the winning player(s) are forced to 7'b1111111.
  - The loser's digits remain steady.
- Input pulses longer than 1 cycle count once per cycle high. Edge detection is the caller's responsibility.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles, release -> scores 00/00, HEX0=HEX2=7'b1000000, HEX1=HEX3=7'b1111111, game_over=0, winner=00.
2. BCD carry: 10 point_p1 pulses -> score_p1=8'h10, HEX3=7'b1111001, HEX2=7'b1000000. Each pulse is reflected one cycle later.
3. Win and blink (WIN_SCORE=11, BLINK_HALF=4):
   - P1 reaches 11 -> game_over=1, winner=01 in that same cycle.
   - HEX3/HEX2 show "11" for 4 cycles, then 7'b1111111 for 4 cycles, repeating.
   - HEX1/HEX0 stay steady.
   - Further point_p2 pulses leave score_p2 unchanged.
4. Draw: both players at 10, then point_p1 and point_p2 in the same cycle -> both scores 8'h11, winner=11, all four digits blink.
5. Priority: in PLAY with score 5-3, pulse new_game together with point_p2 -> next cycle scores 00/00, state PLAY, winner=00.
6. Reset mid-blink: in GAME_OVER during the hidden phase, pulse rst_n=0 for 1 cycle -> next cycle the reset values of scenario 1, game_over=0.
